ws_feeder: RTL and testbench
============================

WS_FEEDER -- requirements
Module: ws_feeder

Interface
REQ-001 Parameters, one per line: DATA_WIDTH, 8, element width; ARRAY_DIM, 4, rows/columns of the square weight-stationary array.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- i_start  in  1  pulse, begins one tile job; sampled only in IDLE.
- i_num_vec  in  16  fmap vectors in the job; sampled with i_start.
- i_w_valid / o_w_ready / i_w_data  in / out / ARRAY_DIM*DATA_WIDTH  weight-row stream; lane c feeds column c.
- i_f_valid / o_f_ready / i_f_data  in / out / ARRAY_DIM*DATA_WIDTH  fmap-vector stream; lane r feeds row r.
- o_load  out  1  drives the array's weight-load enable.
- o_weight  out  ARRAY_DIM*DATA_WIDTH  top-of-column weights into the array.
- o_fmap  out  ARRAY_DIM*DATA_WIDTH  left-edge fmaps into the array.
- o_vec_valid  out  1  high when a real, non-bubble vector enters lane 0.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at job end.

Function
REQ-003 The FSM SHALL have states IDLE, WFILL, WSHIFT, COMPUTE and DRAIN.
REQ-004 IDLE: i_start SHALL latch i_num_vec and move to WFILL; i_start in any other state SHALL be ignored.
REQ-005 WFILL: o_w_ready=1; each i_w_valid&o_w_ready handshake SHALL write row index 0..ARRAY_DIM-1 into the weight buffer in arrival order; after ARRAY_DIM handshakes -> WSHIFT.
REQ-006 WSHIFT: exactly ARRAY_DIM cycles with o_load=1, emitting buffered rows in reverse order (row ARRAY_DIM-1 first), so row 0 ends in the top PE row; then -> COMPUTE, or -> IDLE with o_done if the latched count is 0.
REQ-007 o_weight SHALL be 0 whenever o_load=0; o_load and o_weight SHALL be registered outputs.
REQ-008 COMPUTE: o_f_ready=1 until i_num_vec vectors are accepted; a cycle without a handshake SHALL inject an all-zero vector with o_vec_valid=0, because the array cannot stall.
REQ-009 After the last accepted vector -> DRAIN: zero vectors for DRAIN_LEN cycles, o_f_ready=0, then -> IDLE with o_done=1 for one cycle.
REQ-010 o_w_ready SHALL be 0 outside WFILL; o_f_ready SHALL be 0 outside COMPUTE; o_load SHALL be 0 outside WSHIFT.
REQ-011 The vector counter SHALL be 16-bit and SHALL NOT wrap; i_num_vec=65535 SHALL complete normally.
REQ-012 When a handshake on the last vector occurs, the transition to DRAIN SHALL happen in the same cycle; no extra bubble is inserted.

Reset
REQ-013 While rstn=0 at a clock edge: FSM -> IDLE, counters and buffer cleared, and all outputs 0 (o_load, o_weight, o_fmap, o_vec_valid, o_busy, o_done, o_w_ready, o_f_ready).
REQ-014 Reset asserted mid-job SHALL abort the job without an o_done pulse; skew registers SHALL be cleared.

Configuration
REQ-015 Macro WS_FEEDER_SKEW_EN defined: lane r of o_fmap SHALL be delayed by r+1 cycles through internal skew registers, and DRAIN_LEN = 2*ARRAY_DIM-1.
REQ-016 Macro WS_FEEDER_SKEW_EN undefined: all lanes SHALL be delayed by 1 cycle (no skew; the skew is external), and DRAIN_LEN = ARRAY_DIM.
REQ-017 o_vec_valid SHALL always align with lane 0 in both builds.

Structure
REQ-018 A shared package ws_pkg SHALL hold the FSM state encoding, the DRAIN_LEN computation, and the default DATA_WIDTH and ARRAY_DIM.
REQ-019 The per-lane delay line SHALL be a sub-module ws_skew_line, parameterised by depth, instantiated once per lane.

Verification (DIM=4, DW=8)
REQ-020 Weight rows 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 -> o_load high 4 cycles emitting 0x0D0E0F10, 0x090A0B0C, 0x05060708, 0x01020304 in that order; o_weight=0 before and after.
REQ-021 i_num_vec=3, fmap 0x04030201 accepted every cycle, skew build -> lane0=0x01 at t+1, lane1=0x02 at t+2, lane2=0x03 at t+3, lane3=0x04 at t+4; o_done exactly 7 cycles after the final handshake's drain starts.
REQ-022 i_f_valid toggled 1,0,1 with i_num_vec=2 -> one zero-vector bubble with o_vec_valid=0 between the two real vectors.
REQ-023 i_num_vec=0 -> after WSHIFT, o_done pulses with no COMPUTE or DRAIN, and o_f_ready stays 0.
REQ-024 rstn low for one cycle mid-COMPUTE -> all outputs 0 on the next cycle, state IDLE, no o_done; a subsequent i_start runs a full job correctly.

Source files
------------

// File: rtl/ws_feeder_pkg.sv
// Shared definitions for the weight-stationary feeder: FSM states, default sizes
// and lane timing. WS_FEEDER_SKEW_EN selects internal fmap skew and the longer drain.
package ws_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ARRAY_DIM  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WSHIFT,
    COMPUTE,
    DRAIN
  } state_t;

  // Zero cycles fed after the last vector so the array can flush its last wavefront
  function automatic int drain_len(input int dim);
`ifdef WS_FEEDER_SKEW_EN
    return 2 * dim - 1;
`else
    return dim;
`endif
  endfunction

  function automatic int lane_depth(input int lane);
`ifdef WS_FEEDER_SKEW_EN
    return lane + 1;
`else
    return 1;
`endif
  endfunction

endpackage

// File: rtl/ws_feeder_skew_line.sv
// Per-lane fmap delay line: a DEPTH-stage register chain, cleared by reset.
module ws_skew_line
  import ws_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/ws_feeder.sv
// Feeds a square weight-stationary array: buffers a weight tile, shifts it in
// bottom-row first, then streams fmap vectors with zero bubbles. Macro: WS_FEEDER_SKEW_EN.
module ws_feeder
  import ws_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_DIM  = DEF_ARRAY_DIM
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_start,
  input  logic [15:0]                     i_num_vec,
  input  logic                            i_w_valid,
  output logic                            o_w_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] i_w_data,
  input  logic                            i_f_valid,
  output logic                            o_f_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] i_f_data,
  output logic                            o_load,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] o_weight,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] o_fmap,
  output logic                            o_vec_valid,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int VW = ARRAY_DIM * DATA_WIDTH;
  localparam int CW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam logic [CW-1:0] IDX_LAST   = CW'(ARRAY_DIM - 1);
  localparam logic [15:0]   DRAIN_LAST = 16'(drain_len(ARRAY_DIM) - 1);

  state_t          r_state;
  logic [15:0]     r_num_vec;
  logic [15:0]     r_vec_cnt;
  logic [15:0]     r_drain_cnt;
  logic [CW-1:0]   r_wcnt;
  logic [VW-1:0]   r_wbuf [ARRAY_DIM];
  logic            r_load;
  logic [VW-1:0]   r_weight;
  logic            r_w_ready;
  logic            r_f_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_vec_valid;
  logic            w_w_hs;
  logic            w_f_hs;
  logic [VW-1:0]   w_fmap_in;
  logic [VW-1:0]   w_fmap_out;

  assign w_w_hs    = i_w_valid & r_w_ready;
  assign w_f_hs    = i_f_valid & r_f_ready;
  assign w_fmap_in = w_f_hs ? i_f_data : '0;

  // r_wcnt counts arriving rows in WFILL and is reused as the shift index in WSHIFT
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_num_vec   <= '0;
      r_vec_cnt   <= '0;
      r_drain_cnt <= '0;
      r_wcnt      <= '0;
      r_load      <= 1'b0;
      r_weight    <= '0;
      r_w_ready   <= 1'b0;
      r_f_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vec_valid <= 1'b0;
      for (int i = 0; i < ARRAY_DIM; i++) r_wbuf[i] <= '0;
    end else begin
      r_done      <= 1'b0;
      r_vec_valid <= w_f_hs;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_num_vec <= i_num_vec;
            r_wcnt    <= '0;
            r_w_ready <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= WFILL;
          end
        end
        WFILL: begin
          if (w_w_hs) begin
            r_wbuf[r_wcnt] <= i_w_data;
            r_wcnt         <= r_wcnt + 1'b1;
            if (r_wcnt == IDX_LAST) begin
              r_wcnt    <= '0;
              r_w_ready <= 1'b0;
              r_load    <= 1'b1;
              r_weight  <= i_w_data;
              r_state   <= WSHIFT;
            end
          end
        end
        WSHIFT: begin
          if (r_wcnt == IDX_LAST) begin
            r_load   <= 1'b0;
            r_weight <= '0;
            if (r_num_vec == 16'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_vec_cnt <= '0;
              r_f_ready <= 1'b1;
              r_state   <= COMPUTE;
            end
          end else begin
            r_wcnt   <= r_wcnt + 1'b1;
            r_weight <= r_wbuf[IDX_LAST - r_wcnt - CW'(1)];
          end
        end
        COMPUTE: begin
          if (w_f_hs) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
            if (r_vec_cnt == r_num_vec - 16'd1) begin
              r_f_ready   <= 1'b0;
              r_drain_cnt <= '0;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_lane
    ws_skew_line #(
      .WIDTH(DATA_WIDTH),
      .DEPTH(lane_depth(r))
    ) u_line (
      .clk   (clk),
      .rstn  (rstn),
      .i_data(w_fmap_in[r*DATA_WIDTH +: DATA_WIDTH]),
      .o_data(w_fmap_out[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign o_w_ready   = r_w_ready;
  assign o_f_ready   = r_f_ready;
  assign o_load      = r_load;
  assign o_weight    = r_weight;
  assign o_fmap      = w_fmap_out;
  assign o_vec_valid = r_vec_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_ws_feeder.sv
// Self-checking bench for ws_feeder: randomized jobs checked cycle by cycle against
// an event-schedule reference model; honours WS_FEEDER_SKEW_EN for lane timing.
module tb_ws_feeder;

  localparam int DIM = 4;
  localparam int DW  = 8;
  localparam int VW  = DIM * DW;
`ifdef WS_FEEDER_SKEW_EN
  localparam int DL = 2 * DIM - 1;
`else
  localparam int DL = DIM;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_start;
  logic [15:0]   i_num_vec;
  logic          i_w_valid;
  logic          o_w_ready;
  logic [VW-1:0] i_w_data;
  logic          i_f_valid;
  logic          o_f_ready;
  logic [VW-1:0] i_f_data;
  logic          o_load;
  logic [VW-1:0] o_weight;
  logic [VW-1:0] o_fmap;
  logic          o_vec_valid;
  logic          o_busy;
  logic          o_done;

  int nChecks = 0;
  int nFail   = 0;

  ws_feeder #(.DATA_WIDTH(DW), .ARRAY_DIM(DIM)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_num_vec(i_num_vec),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
    .i_f_valid(i_f_valid), .o_f_ready(o_f_ready), .i_f_data(i_f_data),
    .o_load(o_load), .o_weight(o_weight), .o_fmap(o_fmap),
    .o_vec_valid(o_vec_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  function automatic int lane_delay(input int r);
`ifdef WS_FEEDER_SKEW_EN
    return r + 1;
`else
    return 1;
`endif
  endfunction

  function automatic logic [DIM*VW-1:0] rand_rows();
    logic [DIM*VW-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*VW +: VW] = $urandom;
    return v;
  endfunction

  // Runs one job from IDLE; every cycle's outputs are predicted from the job's event
  // schedule (weight arrival, reversed load window, accepted vectors, drain length).
  task automatic test_job(input int nvec, input logic [DIM*VW-1:0] rows, input int fmode,
                          input bit wrand, output int obsDone, output int lastHs,
                          output int obsVv, output int obsGap, output int obsFr);
    logic [VW-1:0] fed [int];
    logic [VW-1:0] expW, expF, fd, tmp;
    int c, wacc, facc, wl, doneAt, pendGap, limit;
    bit expWr, expFr, expBusy, expLoad, expVv, wv, fv, seenVv, reached;
    fed.delete();
    c = 0; wacc = 0; facc = 0; wl = -1; lastHs = -1; doneAt = 1 << 30;
    obsDone = -1; obsVv = 0; obsGap = 0; obsFr = 0; pendGap = 0; seenVv = 0; reached = 0;
    limit = nvec * 4 + 200;
    while (c < limit) begin
      expWr   = (c >= 1) && (wacc < DIM);
      expFr   = (wl >= 0) && (nvec > 0) && (c >= wl + DIM + 1) && (facc < nvec);
      expBusy = (c >= 1) && (c < doneAt);
      expLoad = (wl >= 0) && (c > wl) && (c <= wl + DIM);
      expW    = expLoad ? rows[(DIM - 1 - (c - wl - 1))*VW +: VW] : '0;
      expVv   = fed.exists(c - 1);
      expF    = '0;
      for (int r = 0; r < DIM; r++) begin
        if (fed.exists(c - lane_delay(r))) begin
          tmp = fed[c - lane_delay(r)];
          expF[r*DW +: DW] = tmp[r*DW +: DW];
        end
      end
      if (c >= 1) begin
        nChecks += 8;
        if (o_w_ready !== expWr) begin nFail++; $display("[TB] FAIL job c=%0d o_w_ready got %0b want %0b", c, o_w_ready, expWr); end
        if (o_f_ready !== expFr) begin nFail++; $display("[TB] FAIL job c=%0d o_f_ready got %0b want %0b", c, o_f_ready, expFr); end
        if (o_load !== expLoad) begin nFail++; $display("[TB] FAIL job c=%0d o_load got %0b want %0b", c, o_load, expLoad); end
        if (o_weight !== expW) begin nFail++; $display("[TB] FAIL job c=%0d o_weight got %h want %h", c, o_weight, expW); end
        if (o_fmap !== expF) begin nFail++; $display("[TB] FAIL job c=%0d o_fmap got %h want %h", c, o_fmap, expF); end
        if (o_vec_valid !== expVv) begin nFail++; $display("[TB] FAIL job c=%0d o_vec_valid got %0b want %0b", c, o_vec_valid, expVv); end
        if (o_busy !== expBusy) begin nFail++; $display("[TB] FAIL job c=%0d o_busy got %0b want %0b", c, o_busy, expBusy); end
        if (o_done !== (c == doneAt)) begin nFail++; $display("[TB] FAIL job c=%0d o_done got %0b want %0b", c, o_done, (c == doneAt)); end
        if (o_done === 1'b1 && obsDone < 0) obsDone = c;
        if (o_f_ready === 1'b1) obsFr++;
        if (o_vec_valid === 1'b1) begin
          obsVv++; obsGap += pendGap; pendGap = 0; seenVv = 1;
        end else if (seenVv) begin
          pendGap++;
        end
      end
      if (c == doneAt) begin
        reached = 1;
        i_start = 1'b0; i_w_valid = 1'b0; i_f_valid = 1'b0;
        break;
      end
      i_start   = (c == 0) || (expBusy && ($urandom_range(0, 3) == 0));
      i_num_vec = (c == 0) ? 16'(nvec) : 16'($urandom);
      wv = expWr ? (wrand ? 1'($urandom_range(0, 1)) : 1'b1) : 1'($urandom_range(0, 1));
      i_w_valid = wv;
      i_w_data  = expWr ? rows[wacc*VW +: VW] : VW'($urandom);
      fd = VW'($urandom);
      case (fmode)
        0:       fv = 1'b1;
        1:       fv = 1'($urandom_range(0, 1));
        2:       fv = (wl < 0) || (((c - wl - DIM - 1) & 1) == 0);
        default: begin fv = 1'b1; fd = 32'h04030201; end
      endcase
      i_f_valid = fv;
      i_f_data  = fd;
      if (wv && expWr) begin
        wacc++;
        if (wacc == DIM) begin
          wl = c;
          if (nvec == 0) doneAt = c + DIM + 1;
        end
      end
      if (fv && expFr) begin
        fed[c] = fd;
        facc++;
        if (facc == nvec) begin
          lastHs = c;
          doneAt = c + DL + 1;
        end
      end
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    nChecks++;
    if (!reached) begin
      nFail++;
      $display("[TB] FAIL job timeout nvec=%0d got cycle %0d want done by %0d", nvec, c, doneAt);
      i_start = 1'b0; i_w_valid = 1'b0; i_f_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_start = 1'b0; i_num_vec = '0; i_w_valid = 1'b0; i_w_data = '0;
    i_f_valid = 1'b0; i_f_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks += 3;
    if ({o_load, o_w_ready, o_f_ready, o_vec_valid, o_busy, o_done} !== 6'b0) begin
      nFail++; $display("[TB] FAIL reset flags got %b want 000000", {o_load, o_w_ready, o_f_ready, o_vec_valid, o_busy, o_done});
    end
    if (o_weight !== '0) begin nFail++; $display("[TB] FAIL reset o_weight got %h want 0", o_weight); end
    if (o_fmap !== '0) begin nFail++; $display("[TB] FAIL reset o_fmap got %h want 0", o_fmap); end
    rstn = 1'b1;
  endtask

  task automatic test_weight_order();
    int d, h, v, g, f;
    test_job(1, {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304}, 0, 1'b0, d, h, v, g, f);
  endtask

  task automatic test_skew();
    int d, h, v, g, f;
    test_job(3, rand_rows(), 3, 1'b0, d, h, v, g, f);
    nChecks++;
    if (d - h - 1 !== DL) begin nFail++; $display("[TB] FAIL skew done_after_drain_start got %0d want %0d", d - h - 1, DL); end
  endtask

  task automatic test_bubble();
    int d, h, v, g, f;
    test_job(2, rand_rows(), 2, 1'b0, d, h, v, g, f);
    nChecks += 2;
    if (v !== 2) begin nFail++; $display("[TB] FAIL bubble vec_valid_pulses got %0d want 2", v); end
    if (g !== 1) begin nFail++; $display("[TB] FAIL bubble gap_cycles got %0d want 1", g); end
  endtask

  task automatic test_zero_count();
    int d, h, v, g, f;
    test_job(0, rand_rows(), 1, 1'b1, d, h, v, g, f);
    nChecks += 2;
    if (f !== 0) begin nFail++; $display("[TB] FAIL zero_count f_ready_cycles got %0d want 0", f); end
    if (v !== 0) begin nFail++; $display("[TB] FAIL zero_count vec_valid_pulses got %0d want 0", v); end
  endtask

  task automatic test_random();
    int d, h, v, g, f;
    for (int j = 0; j < 4; j++) test_job($urandom_range(1, 24), rand_rows(), 1, 1'b1, d, h, v, g, f);
  endtask

  task automatic test_mid_reset();
    int k, d, h, v, g, f;
    i_start = 1'b1; i_num_vec = 16'd5;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0; i_w_valid = 1'b1; i_w_data = $urandom;
    k = 0;
    while (o_f_ready !== 1'b1 && k < 20) begin
      @(posedge clk); @(negedge clk); k++;
    end
    nChecks++;
    if (o_f_ready !== 1'b1) begin nFail++; $display("[TB] FAIL mid_reset reach_compute got %0b want 1", o_f_ready); end
    i_w_valid = 1'b0; i_f_valid = 1'b1; i_f_data = 32'hA1B2C3D4;
    @(posedge clk); @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    nChecks += 3;
    if ({o_load, o_w_ready, o_f_ready, o_vec_valid, o_busy, o_done} !== 6'b0) begin
      nFail++; $display("[TB] FAIL mid_reset flags got %b want 000000", {o_load, o_w_ready, o_f_ready, o_vec_valid, o_busy, o_done});
    end
    if (o_weight !== '0) begin nFail++; $display("[TB] FAIL mid_reset o_weight got %h want 0", o_weight); end
    if (o_fmap !== '0) begin nFail++; $display("[TB] FAIL mid_reset o_fmap got %h want 0", o_fmap); end
    rstn = 1'b1; i_f_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      nChecks++;
      if ({o_done, o_busy} !== 2'b00) begin nFail++; $display("[TB] FAIL mid_reset idle_after got done,busy=%b want 00", {o_done, o_busy}); end
    end
    test_job(4, rand_rows(), 1, 1'b1, d, h, v, g, f);
  endtask

  task automatic test_max_count();
    int d, h, v, g, f;
    test_job(65535, rand_rows(), 0, 1'b0, d, h, v, g, f);
    nChecks++;
    if (d - h - 1 !== DL) begin nFail++; $display("[TB] FAIL max_count done_after_drain_start got %0d want %0d", d - h - 1, DL); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_weight_order();
    test_skew();
    test_bubble();
    test_zero_count();
    test_random();
    test_mid_reset();
    test_max_count();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
